// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART sequencing controller: FSM state encodings and byte width.
// No logic lives here.
package uart_ctrl_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_LOAD = 2'd1,
      T_WAIT = 2'd2
   } tx_state_e;

   typedef enum logic {
      R_IDLE   = 1'b0,
      R_UNLOAD = 1'b1
   } rx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, scanning upward with wrap.
// Purely combinational; no state, no backpressure of its own.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic found;
   int   idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_ctrl.sv
// Shares the UART transmitter among N_REQ requesters (round-robin) and drains the receiver
// into a one-entry valid/ready buffer; all outputs registered, handshakes bounded by TIMEOUT.
module uart_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [8*N_REQ-1:0]      req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    ctl_tx_en,
   input  logic                    ctl_rx_en,
   input  logic                    clr_err,
   output logic                    uart_ld_tx_data,
   output logic [7:0]              uart_tx_data,
   input  logic                    uart_tx_empty,
   output logic                    uart_tx_enable,
   output logic                    uart_uld_rx_data,
   input  logic [7:0]              uart_rx_data,
   input  logic                    uart_rx_empty,
   output logic                    uart_rx_enable,
   output logic                    rx_valid,
   output logic [7:0]              rx_byte,
   input  logic                    rx_ready,
   output logic                    rx_overrun,
   output logic                    tx_timeout,
   output logic                    tx_busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   tx_state_e          tx_state_q, tx_state_d;
   rx_state_e          rx_state_q, rx_state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [TO_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic [TO_W-1:0]    rx_cnt_q, rx_cnt_d;
   logic [N_REQ-1:0]   req_ready_q, req_ready_d;
   logic               ld_q, ld_d;
   logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
   logic               uld_q, uld_d;
   logic               rx_valid_q, rx_valid_d;
   logic [BYTE_W-1:0]  rx_byte_q, rx_byte_d;
   logic               rx_overrun_q, rx_overrun_d;
   logic               tx_timeout_q, tx_timeout_d;
   logic               tx_busy_q, tx_busy_d;
   logic               tx_en_q, rx_en_q;

   logic [N_REQ-1:0]   gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic [BYTE_W-1:0]  sel_byte;
   logic               tx_to_evt, rx_to_evt, rx_cap, rx_drop, rx_pop;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel_byte = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) sel_byte = sel_byte | req_data[i*BYTE_W +: BYTE_W];
      end
   end

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      ptr_d       = ptr_q;
      req_ready_d = '0;
      ld_d        = ld_q;
      tx_data_d   = tx_data_q;
      tx_to_evt   = 1'b0;
      case (tx_state_q)
         T_IDLE: begin
            if (uart_tx_empty && tx_en_q && (|req_valid)) begin
               req_ready_d = gnt;
               tx_data_d   = sel_byte;
               ptr_d       = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
               ld_d        = 1'b1;
               tx_cnt_d    = '0;
               tx_state_d  = T_LOAD;
            end
         end
         T_LOAD: begin
            if (!uart_tx_empty) begin
               ld_d       = 1'b0;
               tx_cnt_d   = '0;
               tx_state_d = T_WAIT;
            end else if (tx_cnt_q == TO_LAST) begin
               ld_d       = 1'b0;
               tx_to_evt  = 1'b1;
               tx_state_d = T_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + TO_W'(1);
            end
         end
         T_WAIT: begin
            if (uart_tx_empty) begin
               tx_state_d = T_IDLE;
            end else if (tx_cnt_q == TO_LAST) begin
               tx_to_evt  = 1'b1;
               tx_state_d = T_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + TO_W'(1);
            end
         end
         default: tx_state_d = T_IDLE;
      endcase
      tx_busy_d    = (tx_state_d != T_IDLE);
      tx_timeout_d = tx_to_evt ? 1'b1 : (clr_err ? 1'b0 : tx_timeout_q);
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      uld_d      = uld_q;
      rx_cap     = 1'b0;
      rx_to_evt  = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (!uart_rx_empty && rx_en_q) begin
               uld_d      = 1'b1;
               rx_cnt_d   = '0;
               rx_state_d = R_UNLOAD;
            end
         end
         R_UNLOAD: begin
            if (uart_rx_empty) begin
               uld_d      = 1'b0;
               rx_cap     = 1'b1;
               rx_state_d = R_IDLE;
            end else if (rx_cnt_q == TO_LAST) begin
               uld_d      = 1'b0;
               rx_to_evt  = 1'b1;
               rx_state_d = R_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + TO_W'(1);
            end
         end
         default: rx_state_d = R_IDLE;
      endcase

      // A slot freed by this cycle's transfer can be refilled in the same cycle.
      rx_pop     = rx_valid_q & rx_ready;
      rx_valid_d = rx_valid_q & ~rx_pop;
      rx_byte_d  = rx_byte_q;
      rx_drop    = 1'b0;
      if (rx_cap) begin
         if (!rx_valid_q || rx_pop) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = uart_rx_data;
         end else begin
            rx_drop = 1'b1;
         end
      end
      rx_overrun_d = (rx_drop || rx_to_evt) ? 1'b1 : (clr_err ? 1'b0 : rx_overrun_q);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_state_q   <= T_IDLE;
         rx_state_q   <= R_IDLE;
         ptr_q        <= '0;
         tx_cnt_q     <= '0;
         rx_cnt_q     <= '0;
         req_ready_q  <= '0;
         ld_q         <= 1'b0;
         tx_data_q    <= '0;
         uld_q        <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_byte_q    <= '0;
         rx_overrun_q <= 1'b0;
         tx_timeout_q <= 1'b0;
         tx_busy_q    <= 1'b0;
         tx_en_q      <= 1'b0;
         rx_en_q      <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         rx_state_q   <= rx_state_d;
         ptr_q        <= ptr_d;
         tx_cnt_q     <= tx_cnt_d;
         rx_cnt_q     <= rx_cnt_d;
         req_ready_q  <= req_ready_d;
         ld_q         <= ld_d;
         tx_data_q    <= tx_data_d;
         uld_q        <= uld_d;
         rx_valid_q   <= rx_valid_d;
         rx_byte_q    <= rx_byte_d;
         rx_overrun_q <= rx_overrun_d;
         tx_timeout_q <= tx_timeout_d;
         tx_busy_q    <= tx_busy_d;
         tx_en_q      <= ctl_tx_en;
         rx_en_q      <= ctl_rx_en;
      end
   end

   assign req_ready        = req_ready_q;
   assign uart_ld_tx_data  = ld_q;
   assign uart_tx_data     = tx_data_q;
   assign uart_tx_enable   = tx_en_q;
   assign uart_uld_rx_data = uld_q;
   assign uart_rx_enable   = rx_en_q;
   assign rx_valid         = rx_valid_q;
   assign rx_byte          = rx_byte_q;
   assign rx_overrun       = rx_overrun_q;
   assign tx_timeout       = tx_timeout_q;
   assign tx_busy          = tx_busy_q;

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Sequencing controller in front of the `uart` core. It shares the single UART transmitter between N requesters using round-robin arbitration, and drives the core's ld_tx_data / tx_empty handshake.
- It also drains the receiver automatically through the uld_rx_data / rx_empty handshake into a one-entry output buffer with valid/ready.
- It sits between fabric logic and the `uart` core. The UART txclk and rxclk are tied to the same clk as this block.

Parameters:
- N_REQ, 4, number of TX requesters (2..8).
- TIMEOUT, 1024, max clk cycles to wait for any UART flag transition before abort.
- TO_W, 11, width of timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; also drives UART txclk/rxclk.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte-valid.
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester.
- ctl_tx_en  in  1  software enable for TX; passed through to uart_tx_enable.
- ctl_rx_en  in  1  software enable for RX; passed through to uart_rx_enable.
- clr_err  in  1  clears the sticky error flags.
- uart_ld_tx_data  out  1  to core ld_tx_data.
- uart_tx_data  out  8  to core tx_data.
- uart_tx_empty  in  1  from core tx_empty.
- uart_tx_enable  out  1  to core tx_enable.
- uart_uld_rx_data  out  1  to core uld_rx_data.
- uart_rx_data  in  8  from core rx_data.
- uart_rx_empty  in  1  from core rx_empty.
- uart_rx_enable  out  1  to core rx_enable.
- rx_valid  out  1  received byte available.
- rx_byte  out  8  received byte.
- rx_ready  in  1  consumer accepts rx_byte.
- rx_overrun  out  1  sticky: a byte was dropped because the buffer was full.
- tx_timeout  out  1  sticky: a TX handshake abort occurred.
- tx_busy  out  1  TX FSM is not in T_IDLE.

Behaviour:
- Reset (reset_n=0 at posedge clk) puts every output to 0:
  - req_ready, uart_ld_tx_data, uart_tx_data, uart_uld_rx_data, rx_valid, rx_byte, rx_overrun, tx_timeout, tx_busy.
  - uart_tx_enable and uart_rx_enable are also 0.
  - Round-robin pointer returns to requester 0.
  - Both FSMs go to idle.
- uart_tx_enable and uart_rx_enable are registered copies of ctl_tx_en and ctl_rx_en (1-cycle latency).
- TX FSM:
  - T_IDLE: grant happens when uart_tx_empty=1, uart_tx_enable=1 and any req_valid is set.
    - Winner is the first set req_valid at or after the rr pointer, scanning upward and wrapping.
    - Latch req_data[winner] into uart_tx_data.
    - Pulse req_ready[winner] for exactly 1 cycle.
    - Set rr pointer to winner+1 mod N_REQ.
    - Go to T_LOAD.
  - T_LOAD:
    - uart_ld_tx_data=1.
    - When uart_tx_empty=0 is sampled: deassert ld next cycle and go to T_WAIT.
  - T_WAIT:
    - Hold uart_tx_data stable.
    - When uart_tx_empty=1 is sampled: go to T_IDLE.
    - The next grant is no earlier than the cycle after that.
  - Timeout: a counter resets on every state entry and counts in T_LOAD and T_WAIT.
    - When it reaches TIMEOUT: set tx_timeout, drop ld, go to T_IDLE.
    - The byte counts as consumed; it is not retried.
  - ctl_tx_en falling mid-frame does not abort the FSM; only the timeout does.
- RX FSM:
  - R_IDLE: when uart_rx_empty=0 and uart_rx_enable=1, go to R_UNLOAD.
  - R_UNLOAD:
    - uart_uld_rx_data=1.
    - When uart_rx_empty=1 is sampled: drop uld next cycle.
    - In that same sampling cycle, capture uart_rx_data into the buffer.
    - Go to R_IDLE.
  - Buffer and overrun:
    - If the buffer is empty, or emptied this cycle (rx_valid & rx_ready), load it and set rx_valid=1.
    - Otherwise discard the byte and set rx_overrun.
  - R_UNLOAD has its own TIMEOUT counter. Expiry drops uld, returns to R_IDLE and sets rx_overrun.
- Output buffer handshake:
  - Transfer occurs when rx_valid & rx_ready.
  - rx_valid clears the next cycle unless it is reloaded in that same cycle.
  - rx_byte is stable while rx_valid=1 and rx_ready=0.
- Error flags:
  - clr_err clears both sticky flags.
  - If a set event and clr_err occur in the same cycle, set wins.
- Requester rules:
  - A requester must hold req_valid and req_data stable until it sees req_ready.
  - Dropping req_valid early is allowed; an unrequested byte is never sent.

Decomposition:
- uart_ctrl_pkg:
  - TX state enum (T_IDLE, T_LOAD, T_WAIT).
  - RX state enum (R_IDLE, R_UNLOAD).
  - Byte width constant 8.
- Sub-module rr_arbiter (N_REQ parameter):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
  - Pointer register stays in uart_ctrl.

Test Plan:
- Loopback with the `uart` core (tx_out→rx_in), single requester 0 sends 8'h55: exactly one ld pulse; rx_valid goes high with rx_byte=8'h55; rx_overrun=0.
- All 4 requesters valid with 8'h41, 8'h42, 8'h43, 8'h44, pointer at 0, rx_ready=1: req_ready order is 0,1,2,3; received sequence is 41,42,43,44. Then re-raise only req 1 and req 0: order is 0,1 (wrap).
- rx_ready held 0 while two bytes 8'h7D and 8'h01 arrive: rx_byte stays 8'h7D; rx_overrun=1. Then rx_ready=1 for 1 cycle: rx_valid=0. Then clr_err: rx_overrun=0.
- Stub core holds tx_empty=1 after ld: tx_timeout=1 exactly TIMEOUT cycles after T_LOAD entry; FSM returns to idle; next request is still granted.
- reset_n=0 during T_WAIT: next cycle all outputs are 0 and the pointer is 0. After release with tx_empty=1, a new request is granted normally.
- ctl_tx_en=0 with req_valid=1: no req_ready and no ld for 100 cycles. Set ctl_tx_en=1: grant occurs within 3 cycles.
